// File: rtl/char_rotator.sv
// char_rotator: rotates the six-character banner "dE102 " across six
// 7-segment decoder stages. A clock-enable divider produces one rotation
// step every TICK_DIV enabled cycles. Direction is chosen by dir, and load
// returns the banner to its home position.
module char_rotator #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       dir,
    input  logic       load,
    output logic [2:0] code_5,
    output logic [2:0] code_4,
    output logic [2:0] code_3,
    output logic [2:0] code_2,
    output logic [2:0] code_1,
    output logic [2:0] code_0,
    output logic [2:0] pos,
    output logic       tick
);

    // Divider width covers TICK_DIV-1 (TICK_DIV >= 2 keeps this >= 1).
    localparam int unsigned        CNT_W   = $clog2(TICK_DIV);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_ZERO = {CNT_W{1'b0}};

    // Character codes
    localparam logic [2:0] CH_D     = 3'b000;
    localparam logic [2:0] CH_E     = 3'b001;
    localparam logic [2:0] CH_1     = 3'b010;
    localparam logic [2:0] CH_0     = 3'b011;
    localparam logic [2:0] CH_2     = 3'b100;
    localparam logic [2:0] CH_BLANK = 3'b111;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       pos_q, pos_d;
    logic             tick_q, tick_d;

    // Banner sequence lookup. Any out-of-range index shows blank, so the
    // unused codes 101/110 can never reach the decoders.
    function automatic logic [2:0] seq_code(input logic [2:0] idx);
        logic [2:0] c;
        case (idx)
            3'd0:    c = CH_D;
            3'd1:    c = CH_E;
            3'd2:    c = CH_1;
            3'd3:    c = CH_0;
            3'd4:    c = CH_2;
            3'd5:    c = CH_BLANK;
            default: c = CH_BLANK;
        endcase
        return c;
    endfunction

    // (p + off) mod 6, for p in 0..5 and off in 0..5.
    function automatic logic [2:0] rot_index(input logic [2:0] p, input logic [2:0] off);
        logic [3:0] sum;
        logic [3:0] wrapped;
        logic [2:0] r;
        sum     = {1'b0, p} + {1'b0, off};
        wrapped = sum - 4'd6;
        if (sum >= 4'd6) begin
            r = wrapped[2:0];
        end else begin
            r = sum[2:0];
        end
        return r;
    endfunction

    // Next position when rotating left. Any illegal value falls back to home.
    function automatic logic [2:0] pos_inc(input logic [2:0] p);
        logic [2:0] r;
        if (p >= 3'd5) begin
            r = 3'd0;
        end else begin
            r = p + 3'd1;
        end
        return r;
    endfunction

    // Next position when rotating right. Any illegal value falls back to 5.
    function automatic logic [2:0] pos_dec(input logic [2:0] p);
        logic [2:0] r;
        if ((p == 3'd0) || (p > 3'd5)) begin
            r = 3'd5;
        end else begin
            r = p - 3'd1;
        end
        return r;
    endfunction

    // Next-state logic with priority load > en > hold. Reset is applied in the register.
    always_comb begin
        cnt_d  = cnt_q;
        pos_d  = pos_q;
        tick_d = 1'b0;
        if (load) begin
            cnt_d = CNT_ZERO;
            pos_d = 3'd0;
        end else if (en) begin
            if (cnt_q >= CNT_MAX) begin
                cnt_d  = CNT_ZERO;
                tick_d = 1'b1;
                if (dir) begin
                    pos_d = pos_dec(pos_q);
                end else begin
                    pos_d = pos_inc(pos_q);
                end
            end else begin
                cnt_d = cnt_q + CNT_ONE;
            end
        end else begin
            cnt_d = cnt_q;
            pos_d = pos_q;
        end
    end

    // State registers with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q  <= CNT_ZERO;
            pos_q  <= 3'd0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            pos_q  <= pos_d;
            tick_q <= tick_d;
        end
    end

    // Display k shows SEQ[(5 - k + pos) mod 6]. The leftmost display is at offset 0.
    assign code_5 = seq_code(rot_index(pos_q, 3'd0));
    assign code_4 = seq_code(rot_index(pos_q, 3'd1));
    assign code_3 = seq_code(rot_index(pos_q, 3'd2));
    assign code_2 = seq_code(rot_index(pos_q, 3'd3));
    assign code_1 = seq_code(rot_index(pos_q, 3'd4));
    assign code_0 = seq_code(rot_index(pos_q, 3'd5));

    assign pos  = pos_q;
    assign tick = tick_q;

endmodule

// File: tb/tb_char_rotator.sv
// Self-checking bench for char_rotator with TICK_DIV=4. It uses directed
// scenarios plus a randomized run, checked against a behavioural model.
module tb_char_rotator;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       en = 1'b0;
    logic       dir = 1'b0;
    logic       load = 1'b0;
    logic [2:0] code_5, code_4, code_3, code_2, code_1, code_0;
    logic [2:0] pos;
    logic       tick;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    int   m_cnt  = 0;
    int   m_pos  = 0;
    logic m_tick = 1'b0;
    int   seq [6] = '{0, 1, 2, 3, 4, 7};

    int   tick_seen = 0;
    int   tick_pos_q [$];

    localparam logic [17:0] HOME  = {3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b111};
    localparam logic [17:0] POS1  = {3'b001, 3'b010, 3'b011, 3'b100, 3'b111, 3'b000};
    localparam logic [17:0] POS5  = {3'b111, 3'b000, 3'b001, 3'b010, 3'b011, 3'b100};

    char_rotator #(.TICK_DIV(TD)) dut (
        .clk    (clk),
        .reset  (reset),
        .en     (en),
        .dir    (dir),
        .load   (load),
        .code_5 (code_5),
        .code_4 (code_4),
        .code_3 (code_3),
        .code_2 (code_2),
        .code_1 (code_1),
        .code_0 (code_0),
        .pos    (pos),
        .tick   (tick)
    );

    always #5 clk = ~clk;

    function automatic logic [17:0] model_codes(input int p);
        logic [17:0] r;
        r = 18'd0;
        for (int k = 5; k >= 0; k--) begin
            r = {r[14:0], 3'(seq[(5 - k + p) % 6])};
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic l, input logic e, input logic d, input string tag);
        reset = r;
        load  = l;
        en    = e;
        dir   = d;
        @(posedge clk);
        if (r || l) begin
            m_cnt  = 0;
            m_pos  = 0;
            m_tick = 1'b0;
        end else if (e) begin
            if (m_cnt == TD - 1) begin
                m_cnt  = 0;
                m_tick = 1'b1;
                m_pos  = d ? (m_pos + 5) % 6 : (m_pos + 1) % 6;
            end else begin
                m_cnt  = m_cnt + 1;
                m_tick = 1'b0;
            end
        end else begin
            m_tick = 1'b0;
        end
        @(negedge clk);
        if (tick === 1'b1) begin
            tick_seen++;
            tick_pos_q.push_back(int'(pos));
        end
        chk({tag, "_pos"},   18'(pos),   18'(m_pos));
        chk({tag, "_tick"},  18'(tick),  18'(m_tick));
        chk({tag, "_codes"}, {code_5, code_4, code_3, code_2, code_1, code_0}, model_codes(m_pos));
    endtask

    function automatic logic [17:0] dut_codes();
        return {code_5, code_4, code_3, code_2, code_1, code_0};
    endfunction

    initial begin
        // Reset held for two cycles
        step(1'b1, 1'b0, 1'b1, 1'b1, "rst");
        step(1'b1, 1'b0, 1'b0, 1'b0, "rst");
        chk("rst_home", dut_codes(), HOME);
        chk("rst_tick", 18'(tick), 18'd0);

        // First step after four enabled edges
        tick_seen = 0;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0, "first");
        chk("first_tick", 18'(tick), 18'd1);
        chk("first_pos1", dut_codes(), POS1);
        step(1'b0, 1'b0, 1'b1, 1'b0, "first_after");
        chk("first_tick_one_cycle", 18'(tick), 18'd0);

        // Full left revolution over 24 edges
        step(1'b1, 1'b0, 1'b0, 1'b0, "rst2");
        tick_seen = 0;
        tick_pos_q.delete();
        for (int i = 0; i < 24; i++) step(1'b0, 1'b0, 1'b1, 1'b0, "rev");
        chk("rev_ticks", 18'(tick_seen), 18'd6);
        for (int i = 0; i < tick_pos_q.size() && i < 6; i++) begin
            chk("rev_pos_seq", 18'(tick_pos_q[i]), 18'((i + 1) % 6));
        end
        chk("rev_home", dut_codes(), HOME);

        // Right rotation from home
        step(1'b1, 1'b0, 1'b0, 1'b0, "rst3");
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b1, "right");
        chk("right_pos5", 18'(pos), 18'd5);
        chk("right_codes", dut_codes(), POS5);

        // Pause does not count
        step(1'b1, 1'b0, 1'b0, 1'b0, "rst4");
        tick_seen = 0;
        for (int i = 0; i < 2; i++)  step(1'b0, 1'b0, 1'b1, 1'b0, "pause_pre");
        for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b0, "pause");
        chk("pause_no_tick", 18'(tick_seen), 18'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, "pause_post");
        chk("pause_post1_tick", 18'(tick), 18'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, "pause_post");
        chk("pause_post2_tick", 18'(tick), 18'd1);
        chk("pause_pos1", 18'(pos), 18'd1);

        // A direction change mid-interval keeps the count. dir is taken at the step.
        step(1'b1, 1'b0, 1'b0, 1'b0, "rst5");
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b1, 1'b0, "dirmid");
        for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b1, 1'b1, "dirmid");
        chk("dirmid_pos5", 18'(pos), 18'd5);

        // Load with cnt at its maximum wins over en, and the next step takes four edges.
        step(1'b1, 1'b0, 1'b0, 1'b0, "rst6");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, "ld_pre");
        step(1'b0, 1'b1, 1'b1, 1'b0, "ld");
        chk("ld_pos0", 18'(pos), 18'd0);
        chk("ld_tick0", 18'(tick), 18'd0);
        tick_seen = 0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, "ld_post");
        chk("ld_post3_no_tick", 18'(tick_seen), 18'd0);
        step(1'b0, 1'b0, 1'b1, 1'b0, "ld_post");
        chk("ld_post4_tick", 18'(tick), 18'd1);

        // Reset and load together at the maximum count
        step(1'b1, 1'b0, 1'b0, 1'b0, "rst7");
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1, 1'b0, "rl_pre");
        step(1'b1, 1'b1, 1'b1, 1'b1, "rl");
        chk("rl_home", dut_codes(), HOME);
        tick_seen = 0;
        for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 1'b1, 1'b0, "rl_post");
        chk("rl_post_ticks", 18'(tick_seen), 18'd1);

        // Randomized run against the model
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
                 ($urandom_range(0, 3) != 0) ? 1'b1 : 1'b0,
                 1'($urandom_range(0, 1)),
                 "rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
